// File: rtl/counter_pwm_gen_pkg.sv
// Shared definitions for the counter-driven PWM generator.
//   WIDTH_DEFAULT : default width of the incoming count
//   state_t       : duty-buffer state (IDLE / RUN / RUN_PEND)
package counter_pwm_gen_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RUN_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/counter_pwm_gen_count_seq_check.sv
// Watches the free-running count: keeps the previous value, flags the wrap
// to zero (period boundary) and raises a sticky error on any discontinuity.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_counter       : count value from the upstream up counter
//   o_boundary      : combinational, count wrapped to 0 this cycle
//   o_counter_q     : previous cycle's count
//   o_seq_error     : sticky, cleared only by reset
module count_seq_check
  import counter_pwm_gen_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_counter,
  output logic             o_boundary,
  output logic [WIDTH-1:0] o_counter_q,
  output logic             o_seq_error
);

  logic [WIDTH-1:0] r_counter_q;
  logic             r_seq_error;
  logic [WIDTH-1:0] w_counter_inc;
  logic             w_jump;

  // Natural WIDTH-bit wrap makes MAX -> 0 a legal step.
  assign w_counter_inc = r_counter_q + {{(WIDTH-1){1'b0}}, 1'b1};
  // A hold is legal; only a value that is neither the same nor +1 is a jump.
  assign w_jump        = (i_counter != r_counter_q) && (i_counter != w_counter_inc);
  // Holding at zero after a wrap must not re-trigger the boundary.
  assign o_boundary    = (i_counter == '0) && (r_counter_q != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_counter_q <= '0;
      r_seq_error <= 1'b0;
    end else begin
      r_counter_q <= i_counter;
      if (w_jump) r_seq_error <= 1'b1;
    end
  end

  assign o_counter_q = r_counter_q;
  assign o_seq_error = r_seq_error;

endmodule

// File: rtl/counter_pwm_gen.sv
// Registered PWM generator driven by an external up counter. Duty values
// arrive over valid/ready into a shadow register and are promoted to the
// active duty only at a counter wrap, so a period is never glitched.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   counter       : WIDTH-bit count from the upstream up counter
//   duty_in       : requested high time in counts (0..2^WIDTH, larger clamps)
//   duty_valid    : duty_in offered
//   duty_ready    : shadow free (combinational from state)
//   pwm_out       : registered PWM waveform
//   period_start  : registered one-cycle pulse after a wrap
//   active_duty   : duty currently applied
//   seq_error     : sticky count-discontinuity flag
module counter_pwm_gen
  import counter_pwm_gen_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH:0]   duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH:0]   active_duty,
  output logic             seq_error
);

  localparam logic [WIDTH:0] DUTY_FULL = {1'b1, {WIDTH{1'b0}}};

  // Saturate a requested duty to the full period.
  function automatic logic [WIDTH:0] sat_duty(input logic [WIDTH:0] d);
    return (d > DUTY_FULL) ? DUTY_FULL : d;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_shadow;
  logic [WIDTH:0]   r_active_duty;
  logic             r_pwm;
  logic             r_period_start;
  logic [WIDTH:0]   w_eff_duty;
  logic [WIDTH-1:0] w_counter_q;
  logic             w_boundary;
  logic             w_ready;
  logic             w_transfer;
  logic             w_promote;
  logic             w_enable;

  count_seq_check #(.WIDTH(WIDTH)) u_seq (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_counter   (counter),
    .o_boundary  (w_boundary),
    .o_counter_q (w_counter_q),
    .o_seq_error (seq_error)
  );

  assign w_ready    = (r_state != ST_RUN_PEND);
  assign w_transfer = duty_valid && w_ready;
  assign w_promote  = (r_state == ST_RUN_PEND) && w_boundary;
  // The freshly promoted duty already governs the wrap cycle itself.
  assign w_eff_duty = w_promote ? r_shadow : r_active_duty;
  // RUN_PEND entered from IDLE still has active duty 0, so pwm stays low
  // until the first promotion without needing a separate state.
  assign w_enable   = (r_state != ST_IDLE) || w_promote;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_transfer) w_state_nxt = ST_RUN_PEND;
      ST_RUN:      if (w_transfer) w_state_nxt = ST_RUN_PEND;
      ST_RUN_PEND: if (w_boundary) w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Output register stage: one cycle from counter to pwm_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow       <= '0;
      r_active_duty  <= '0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      if (w_transfer) r_shadow      <= sat_duty(duty_in);
      if (w_promote)  r_active_duty <= r_shadow;
      r_pwm          <= w_enable && ({1'b0, counter} < w_eff_duty);
      r_period_start <= w_boundary && w_enable;
    end
  end

  // A boundary is only ever a step from a non-zero count onto zero.
  a_boundary_wrap: assert property (@(posedge clk) disable iff (reset)
    w_boundary |-> ((w_counter_q != '0) && (counter == '0)));

  assign duty_ready   = w_ready;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign active_duty  = r_active_duty;

endmodule

// File: tb/tb_counter_pwm_gen.sv
module tb_counter_pwm_gen;

  localparam int W    = 4;
  localparam int FULL = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] counter;
  logic [W:0]   duty_in;
  logic         duty_valid;
  logic         duty_ready;
  logic         pwm_out;
  logic         period_start;
  logic [W:0]   active_duty;
  logic         seq_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_pwm_gen #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .counter      (counter),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .active_duty  (active_duty),
    .seq_error    (seq_error)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: duty buffering described as "has a duty", "shadow
  // pending", plus values; outputs computed straight from the rules.
  bit m_has, m_pend, armed;
  int m_prev, m_shadow, m_active, m_pwm, m_ps, m_err;
  int c, eff;
  bit bnd, promote, on, xfer;

  always @(posedge clk) begin
    armed = 1'b1;
    if (reset) begin
      m_has = 0; m_pend = 0; m_shadow = 0; m_active = 0;
      m_prev = 0; m_err = 0; m_pwm = 0; m_ps = 0;
    end else begin
      c       = int'(counter);
      bnd     = (c == 0) && (m_prev != 0);
      promote = m_pend && bnd;
      on      = m_has || m_pend;
      eff     = promote ? m_shadow : m_active;
      xfer    = duty_valid && !m_pend;
      m_pwm   = (on && (c < eff)) ? 1 : 0;
      m_ps    = (bnd && on) ? 1 : 0;
      if (c != m_prev && c != (m_prev + 1) % FULL) m_err = 1;
      if (promote) begin m_active = m_shadow; m_pend = 0; m_has = 1; end
      if (xfer) begin
        m_shadow = (int'(duty_in) > FULL) ? FULL : int'(duty_in);
        m_pend   = 1;
      end
      m_prev = c;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("pwm_out",      int'(pwm_out),      m_pwm);
      chk("period_start", int'(period_start), m_ps);
      chk("active_duty",  int'(active_duty),  m_active);
      chk("seq_error",    int'(seq_error),    m_err);
      chk("duty_ready",   int'(duty_ready),   m_pend ? 0 : 1);
    end
  end

  // Stimulus helpers: inputs change only on negedges.
  task automatic adv();
    @(negedge clk);
    counter = counter + 1'b1;
  endtask

  task automatic adv_n(input int n);
    repeat (n) adv();
  endtask

  task automatic goto_cnt(input int v);
    int k;
    k = 0;
    while (int'(counter) != v && k < 40) begin adv(); k++; end
    if (int'(counter) != v) chk("goto_timeout", int'(counter), v);
  endtask

  task automatic offer(input int v);
    bit ok;
    ok = 0;
    duty_in    = 5'(v);
    duty_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = duty_ready;
      adv();
    end
    duty_valid = 1'b0;
    if (!ok) chk("offer_timeout", 0, 1);
  endtask

  task automatic count_period(output int n);
    n = 0;
    repeat (FULL) begin n += int'(pwm_out); adv(); end
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    counter = '0;
    repeat (n) @(negedge clk);
    reset   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    reset = 1'b1; counter = '0; duty_in = '0; duty_valid = 1'b0;

    // 1. reset and free counting with no duty
    do_reset(3);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_active", int'(active_duty), 0);
    chk("rst_err", int'(seq_error), 0);
    chk("rst_ready", int'(duty_ready), 1);
    count_period(n);
    chk("idle_pwm_count", n, 0);

    // 2. first load at count 5, applies at the wrap
    goto_cnt(5);
    offer(4);
    chk("load_ready_drop", int'(duty_ready), 0);
    chk("load_active_before_wrap", int'(active_duty), 0);
    goto_cnt(0);
    adv();
    chk("load_active", int'(active_duty), 4);
    chk("load_period_start", int'(period_start), 1);
    count_period(n);
    chk("duty4_count", n, 4);

    // 3. extremes and clamp
    offer(0);  goto_cnt(0); adv();
    count_period(n); chk("duty0_count", n, 0);
    offer(16); goto_cnt(0); adv();
    count_period(n); chk("duty16_count", n, 16);
    offer(0);  goto_cnt(0); adv();
    offer(20); goto_cnt(0); adv();
    chk("clamp_active", int'(active_duty), 16);
    count_period(n); chk("duty20_count", n, 16);

    // 4. back-to-back loads
    offer(4); goto_cnt(0); adv();
    goto_cnt(3);
    offer(8);
    duty_in = 5'd12; duty_valid = 1'b1;
    k = 0;
    while (!duty_ready && k < 40) begin adv(); k++; end
    chk("b2b_ready_after_wrap", int'(counter), 1);
    chk("b2b_active", int'(active_duty), 8);
    adv();
    duty_valid = 1'b0;
    chk("b2b_second_accepted", int'(duty_ready), 0);
    goto_cnt(0); adv();
    chk("b2b_active2", int'(active_duty), 12);

    // 5. transfer on the wrap cycle
    goto_cnt(0);
    offer(10);
    chk("coll_active_old", int'(active_duty), 12);
    count_period(n);
    chk("coll_old_count", n, 12);
    chk("coll_active_new", int'(active_duty), 10);

    // 6. sequence error, then reset while pending
    goto_cnt(3);
    @(negedge clk); counter = 4'd7;
    adv_n(2);
    chk("seq_err_set", int'(seq_error), 1);
    adv_n(20);
    chk("seq_err_sticky", int'(seq_error), 1);
    offer(6);
    chk("pend_ready", int'(duty_ready), 0);
    do_reset(1);
    chk("rst2_active", int'(active_duty), 0);
    chk("rst2_err", int'(seq_error), 0);
    chk("rst2_ready", int'(duty_ready), 1);
    count_period(n); count_period(n);
    chk("rst2_shadow_lost", n, 0);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      k = $urandom_range(0, 99);
      if (k < 85)      counter = counter + 1'b1;
      else if (k > 96) counter = 4'($urandom_range(0, 15));
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_in    = 5'($urandom_range(0, 31));
      reset      = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0; duty_valid = 1'b0;
    adv_n(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
